snake_body: RTL and testbench

//  Snake movement/length engine; sits directly upstream of the game-state FSM.

---
 rtl/snake_pkg.sv | 55 +++++
 rtl/snake_move_timer.sv | 62 ++++++
 rtl/snake_body.sv | 172 +++++++++++++++++
 tb/tb_snake_body.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake engine: FSM state codes, heading codes,
// length limits and coordinate stepping helpers.
package snake_pkg;

    // Game-state FSM codes as driven back on STATE
    typedef enum logic [4:0] {
        StInitial = 5'd0,
        StGaming  = 5'd1,
        StEnd     = 5'd2,
        StWin     = 5'd3,
        StOver    = 5'd4,
        StChoose  = 5'd5
    } state_e;

    // Heading codes; opposite headings differ only in bit 0
    typedef enum logic [1:0] {
        HdRight = 2'd0,
        HdLeft  = 2'd1,
        HdUp    = 2'd2,
        HdDown  = 2'd3
    } heading_e;

    localparam int NUM_SEG  = 10;
    localparam int INIT_LEN = 3;
    localparam int MAX_LEN  = 10;
    localparam int LEN_W    = 6;
    localparam int COORD_W  = 10;

    // Advance a coordinate one cell; x and y each wrap modulo 32
    function automatic logic [COORD_W-1:0] step(input logic [COORD_W-1:0] coord,
                                                input heading_e           hd);
        logic [4:0] x;
        logic [4:0] y;
        x = coord[9:5];
        y = coord[4:0];
        unique case (hd)
            HdRight: x = x + 5'd1;
            HdLeft:  x = x - 5'd1;
            HdUp:    y = y - 5'd1;
            HdDown:  y = y + 5'd1;
        endcase
        return {x, y};
    endfunction

    // Reverse direction of a heading
    function automatic heading_e opposite(input heading_e hd);
        return heading_e'(2'(hd) ^ 2'b01);
    endfunction

    // Start position of segment i: a horizontal line on row 12, head at x=16
    function automatic logic [COORD_W-1:0] init_seg(input int i);
        return {5'(16 - i), 5'd12};
    endfunction

endpackage

// File: rtl/snake_move_timer.sv
// Move period timer: selects the period from Choose and emits one step per period.
// tick is the terminal-count condition used by the body on the same edge;
// move is its registered copy for the outside world.
module snake_move_timer #(
    parameter int unsigned P_SLOW = 25_000_000,
    parameter int unsigned P_MED  = 12_500_000,
    parameter int unsigned P_FAST = 6_250_000
) (
    input  logic       origin_clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] Choose,
    output logic       tick,
    output logic       move
);

    logic [31:0] period_m1;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        move_q;
    logic        move_d;
    logic        active;

    // Period select and terminal-count detect
    always_comb begin
        period_m1 = 32'd0;
        unique case (Choose)
            2'd1:    period_m1 = 32'(P_SLOW - 1);
            2'd2:    period_m1 = 32'(P_MED - 1);
            2'd3:    period_m1 = 32'(P_FAST - 1);
            default: period_m1 = 32'd0;
        endcase
        active = en && (Choose != 2'd0);
        // >= so that switching to a shorter period past its end fires at once
        tick   = active && (count_q >= period_m1);
    end

    // Counter next state; holds while inactive
    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = 32'd0;
        end else if (active) begin
            count_d = count_q + 32'd1;
        end
        move_d = tick;
    end

    // Counter and move pulse registers
    always_ff @(posedge origin_clk) begin
        if (rst) begin
            count_q <= 32'd0;
            move_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            move_q  <= move_d;
        end
    end

    assign move = move_q;

endmodule

// File: rtl/snake_body.sv
// Snake movement and length engine: heading selection, 10-segment body shift
// register, length tracking and apple/poison hit detection. All outputs are flops.
module snake_body
    import snake_pkg::*;
#(
    parameter int unsigned P_SLOW = 25_000_000,
    parameter int unsigned P_MED  = 12_500_000,
    parameter int unsigned P_FAST = 6_250_000
) (
    input  logic        origin_clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic [4:0]  STATE,
    input  logic [1:0]  Choose,
    input  logic [9:0]  apple,
    input  logic [9:0]  poison,
    output logic [5:0]  length,
    output logic [9:0]  snake0,
    output logic [9:0]  snake1,
    output logic [9:0]  snake2,
    output logic [9:0]  snake3,
    output logic [9:0]  snake4,
    output logic [9:0]  snake5,
    output logic [9:0]  snake6,
    output logic [9:0]  snake7,
    output logic [9:0]  snake8,
    output logic [9:0]  snake9,
    output logic        ate_apple,
    output logic        ate_poison,
    output logic        move
);

    logic               init_load;
    logic               gaming;
    logic               steer_ok;
    logic               tick;

    heading_e           heading_q;
    heading_e           heading_d;
    heading_e           pending_q;
    heading_e           pending_d;
    heading_e           req;
    logic               req_vld;

    logic [COORD_W-1:0] seg_q [NUM_SEG];
    logic [COORD_W-1:0] seg_d [NUM_SEG];
    logic [COORD_W-1:0] new_head;
    logic [LEN_W-1:0]   length_q;
    logic [LEN_W-1:0]   length_d;
    logic               ate_apple_q;
    logic               ate_apple_d;
    logic               ate_poison_q;
    logic               ate_poison_d;

    // INITIAL reloads the start position every cycle, exactly like reset
    assign init_load = rst || (STATE == StInitial);
    assign gaming    = (STATE == StGaming);
    assign steer_ok  = gaming || (STATE == StChoose);

    snake_move_timer #(
        .P_SLOW (P_SLOW),
        .P_MED  (P_MED),
        .P_FAST (P_FAST)
    ) u_timer (
        .origin_clk (origin_clk),
        .rst        (init_load),
        .en         (gaming),
        .Choose     (Choose),
        .tick       (tick),
        .move       (move)
    );

    // Button priority: up > down > left > right
    always_comb begin
        req     = HdRight;
        req_vld = 1'b1;
        if (up) begin
            req = HdUp;
        end else if (down) begin
            req = HdDown;
        end else if (left) begin
            req = HdLeft;
        end else if (right) begin
            req = HdRight;
        end else begin
            req_vld = 1'b0;
        end
    end

    // Pending/committed heading; a request that reverses either the committed
    // or the already-pending heading is dropped so no turn pair can reverse
    always_comb begin
        heading_d = heading_q;
        pending_d = pending_q;
        if (tick) begin
            heading_d = pending_q;
        end
        if (steer_ok && req_vld &&
            (req != opposite(heading_q)) && (req != opposite(pending_q))) begin
            pending_d = req;
        end
    end

    assign new_head = step(seg_q[0], pending_q);

    // Body shift, length update and hit pulses on a move edge
    always_comb begin
        seg_d        = seg_q;
        length_d     = length_q;
        ate_apple_d  = 1'b0;
        ate_poison_d = 1'b0;
        if (tick) begin
            seg_d[0] = new_head;
            for (int i = 1; i < NUM_SEG; i++) begin
                seg_d[i] = seg_q[i-1];
            end
            // Apple takes priority when apple and poison coincide
            if (new_head == apple) begin
                ate_apple_d = 1'b1;
                if (length_q < LEN_W'(MAX_LEN)) begin
                    length_d = length_q + LEN_W'(1);
                end
            end else if (new_head == poison) begin
                ate_poison_d = 1'b1;
                if (length_q != '0) begin
                    length_d = length_q - LEN_W'(1);
                end
            end
        end
    end

    // State registers; reset and INITIAL share the same load
    always_ff @(posedge origin_clk) begin
        if (init_load) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                seg_q[i] <= init_seg(i);
            end
            length_q     <= LEN_W'(INIT_LEN);
            heading_q    <= HdRight;
            pending_q    <= HdRight;
            ate_apple_q  <= 1'b0;
            ate_poison_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SEG; i++) begin
                seg_q[i] <= seg_d[i];
            end
            length_q     <= length_d;
            heading_q    <= heading_d;
            pending_q    <= pending_d;
            ate_apple_q  <= ate_apple_d;
            ate_poison_q <= ate_poison_d;
        end
    end

    assign length     = length_q;
    assign ate_apple  = ate_apple_q;
    assign ate_poison = ate_poison_q;
    assign snake0     = seg_q[0];
    assign snake1     = seg_q[1];
    assign snake2     = seg_q[2];
    assign snake3     = seg_q[3];
    assign snake4     = seg_q[4];
    assign snake5     = seg_q[5];
    assign snake6     = seg_q[6];
    assign snake7     = seg_q[7];
    assign snake8     = seg_q[8];
    assign snake9     = seg_q[9];

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body with short move periods (8/4/2 cycles).
module tb_snake_body;

    logic       origin_clk = 1'b0;
    logic       rst;
    logic       up, down, left, right;
    logic [4:0] STATE;
    logic [1:0] Choose;
    logic [9:0] apple, poison;
    logic [5:0] length;
    logic [9:0] snake0, snake1, snake2, snake3, snake4;
    logic [9:0] snake5, snake6, snake7, snake8, snake9;
    logic       ate_apple, ate_poison, move;

    int checks   = 0;
    int failures = 0;
    int hx, hy, len, moves_seen;

    always #5 origin_clk = ~origin_clk;

    snake_body #(
        .P_SLOW (8),
        .P_MED  (4),
        .P_FAST (2)
    ) dut (
        .origin_clk (origin_clk),
        .rst        (rst),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .STATE      (STATE),
        .Choose     (Choose),
        .apple      (apple),
        .poison     (poison),
        .length     (length),
        .snake0     (snake0),
        .snake1     (snake1),
        .snake2     (snake2),
        .snake3     (snake3),
        .snake4     (snake4),
        .snake5     (snake5),
        .snake6     (snake6),
        .snake7     (snake7),
        .snake8     (snake8),
        .snake9     (snake9),
        .ate_apple  (ate_apple),
        .ate_poison (ate_poison),
        .move       (move)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge origin_clk);
        #1;
    endtask

    // Step until a move pulse is seen, bounded by max_cyc cycles
    task automatic wait_move(input int max_cyc);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (move !== 1'b1 && n < max_cyc);
        check_eq("move_seen", 32'(move), 32'd1);
    endtask

    function automatic logic [9:0] xy(input int x, input int y);
        logic [4:0] xx;
        logic [4:0] yy;
        xx = 5'(x);
        yy = 5'(y);
        return {xx, yy};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; STATE = 5'd0; Choose = 2'd0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        apple = 10'h3FF; poison = 10'h3FF;
        cyc();
        rst = 1'b0;

        // Reset state
        check_eq("rst_length", 32'(length), 32'd3);
        check_eq("rst_snake0", 32'(snake0), 32'h20C);
        check_eq("rst_snake1", 32'(snake1), 32'h1EC);
        check_eq("rst_snake9", 32'(snake9), 32'h0EC);
        check_eq("rst_ate_apple", 32'(ate_apple), 32'd0);
        check_eq("rst_ate_poison", 32'(ate_poison), 32'd0);
        check_eq("rst_move", 32'(move), 32'd0);

        // Fast straight run: move every 2 cycles, heading right
        STATE = 5'd1; Choose = 2'd3;
        wait_move(10);
        check_eq("run1_snake0", 32'(snake0), 32'h22C);
        check_eq("run1_snake1", 32'(snake1), 32'h20C);
        check_eq("run1_length", 32'(length), 32'd3);
        cyc();
        check_eq("run_gap_move", 32'(move), 32'd0);
        cyc();
        check_eq("run2_move", 32'(move), 32'd1);
        check_eq("run2_snake0", 32'(snake0), 32'h24C);
        check_eq("run2_snake1", 32'(snake1), 32'h22C);
        hx = 18; hy = 12;

        // Slow period: reverse request ignored; up then down keeps up
        Choose = 2'd1;
        left = 1'b1; cyc(); left = 1'b0;
        wait_move(12);
        hx = 19;
        check_eq("rev_ignored", 32'(snake0), 32'(xy(19, 12)));
        up = 1'b1; cyc(); up = 1'b0;
        down = 1'b1; cyc(); down = 1'b0;
        wait_move(12);
        hy = 11;
        check_eq("turn_up_head", 32'(snake0), 32'(xy(19, 11)));
        check_eq("turn_up_snake1", 32'(snake1), 32'(xy(19, 12)));

        // Apples ahead of the head: grow 3 -> 10, then saturate
        Choose = 2'd3;
        len = 3;
        for (int k = 0; k < 8; k++) begin
            apple = xy(hx, hy - 1);
            wait_move(4);
            hy = hy - 1;
            len = (len < 10) ? len + 1 : 10;
            check_eq("apple_head", 32'(snake0), 32'(xy(hx, hy)));
            check_eq("apple_pulse", 32'(ate_apple), 32'd1);
            check_eq("apple_len", 32'(length), 32'(len));
        end
        cyc();
        check_eq("apple_pulse_clear", 32'(ate_apple), 32'd0);
        apple = 10'h3FF;

        // Poison ahead of the head: shrink 10 -> 0 with floor; crosses y 0 -> 31
        for (int k = 0; k < 11; k++) begin
            poison = xy(hx, (hy + 31) % 32);
            wait_move(4);
            hy = (hy + 31) % 32;
            len = (len > 0) ? len - 1 : 0;
            check_eq("poison_pulse", 32'(ate_poison), 32'd1);
            check_eq("poison_no_apple", 32'(ate_apple), 32'd0);
            check_eq("poison_len", 32'(length), 32'(len));
            if (hy == 31) begin
                check_eq("ywrap_head", 32'(snake0), 32'(xy(19, 31)));
                check_eq("ywrap_snake1", 32'(snake1), 32'(xy(19, 0)));
            end
        end

        // Apple and poison on the same cell: apple wins
        apple = xy(hx, (hy + 31) % 32);
        poison = apple;
        wait_move(4);
        hy = (hy + 31) % 32;
        check_eq("both_apple", 32'(ate_apple), 32'd1);
        check_eq("both_poison", 32'(ate_poison), 32'd0);
        check_eq("both_len", 32'(length), 32'd1);
        apple = 10'h3FF; poison = 10'h3FF;

        // Turn right and run across x = 31 -> 0
        right = 1'b1; cyc(); right = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wait_move(4);
            hx++;
        end
        check_eq("xrun_head", 32'(snake0), 32'(xy(31, 23)));
        wait_move(4);
        check_eq("xwrap_head", 32'(snake0), 32'(xy(0, 23)));
        check_eq("xwrap_snake1", 32'(snake1), 32'(xy(31, 23)));

        // OVER mid-period freezes everything
        cyc();
        STATE = 5'd4;
        moves_seen = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (move === 1'b1) moves_seen++;
        end
        check_eq("over_moves", 32'(moves_seen), 32'd0);
        check_eq("over_head", 32'(snake0), 32'(xy(0, 23)));
        check_eq("over_len", 32'(length), 32'd1);

        // INITIAL reloads start position
        STATE = 5'd0;
        cyc();
        check_eq("init_head", 32'(snake0), 32'h20C);
        check_eq("init_tail", 32'(snake9), 32'h0EC);
        check_eq("init_len", 32'(length), 32'd3);

        // Reset on the edge that would move onto an apple
        apple = 10'h22C;
        STATE = 5'd1; Choose = 2'd3;
        cyc();
        rst = 1'b1;
        cyc();
        check_eq("rstmove_move", 32'(move), 32'd0);
        check_eq("rstmove_head", 32'(snake0), 32'h20C);
        check_eq("rstmove_len", 32'(length), 32'd3);
        check_eq("rstmove_apple", 32'(ate_apple), 32'd0);
        rst = 1'b0;
        STATE = 5'd0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
